// File: rtl/dcache_writeback_unit.sv
// dcache_writeback_unit: reads one dirty victim line from the data store
// and streams it toward memory as MEM_WIDTH-wide write beats.
module dcache_writeback_unit #(
    parameter  int DATA_WIDTH = 128,
    parameter  int NUM_WORDS  = 256,
    parameter  int TAG_WIDTH  = 20,
    parameter  int MEM_WIDTH  = 32,
    localparam int INDEX_W    = $clog2(NUM_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wb_req_i,
    output logic                    wb_ready_o,
    input  logic [INDEX_W-1:0]      wb_index_i,
    input  logic [TAG_WIDTH-1:0]    wb_tag_i,
    output logic                    wb_done_o,
    output logic                    ds_en_o,
    input  logic                    ds_gnt_i,
    output logic                    ds_we_o,
    output logic [DATA_WIDTH/8-1:0] ds_be_o,
    output logic [INDEX_W-1:0]      ds_addr_o,
    input  logic [DATA_WIDTH-1:0]   ds_rdata_i,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [31:0]             mem_addr_o,
    output logic [MEM_WIDTH-1:0]    mem_wdata_o,
    output logic [MEM_WIDTH/8-1:0]  mem_be_o,
    output logic                    mem_last_o
);

    localparam int NBEATS = DATA_WIDTH / MEM_WIDTH;
    localparam int BEAT_W = $clog2(NBEATS);
    localparam int BOFS_W = $clog2(MEM_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [INDEX_W-1:0]      index_q, index_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   line_q, line_d;
    logic                    wb_ready_q, wb_ready_d;
    logic                    wb_done_q, wb_done_d;
    logic                    ds_en_q, ds_en_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_last_q, mem_last_d;

    logic [NBEATS-1:0][MEM_WIDTH-1:0] line_beats;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                if (wb_req_i) begin
                    index_d = wb_index_i;
                    tag_d   = wb_tag_i;
                    state_d = READ;
                end
            end
            READ: begin
                if (ds_gnt_i) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // SRAM data arrives one cycle after the granted read
                line_d  = ds_rdata_i;
                state_d = SEND;
            end
            SEND: begin
                if (mem_ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs decoded from the next state so they leave a flop
        wb_ready_d  = (state_d == IDLE);
        ds_en_d     = (state_d == READ);
        mem_valid_d = (state_d == SEND);
        mem_last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
        wb_done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            index_q     <= '0;
            tag_q       <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            wb_ready_q  <= 1'b1;
            wb_done_q   <= 1'b0;
            ds_en_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            tag_q       <= tag_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            wb_ready_q  <= wb_ready_d;
            wb_done_q   <= wb_done_d;
            ds_en_q     <= ds_en_d;
            mem_valid_q <= mem_valid_d;
            mem_last_q  <= mem_last_d;
        end
    end

    assign line_beats  = line_q;

    assign wb_ready_o  = wb_ready_q;
    assign wb_done_o   = wb_done_q;
    assign ds_en_o     = ds_en_q;
    assign ds_we_o     = 1'b0;
    assign ds_be_o     = '0;
    assign ds_addr_o   = index_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_last_o  = mem_last_q;
    assign mem_addr_o  = {tag_q, index_q, beat_q, {BOFS_W{1'b0}}};
    assign mem_wdata_o = line_beats[beat_q];
    assign mem_be_o    = {(MEM_WIDTH/8){mem_valid_q}};

endmodule
